product_to_7seg: RTL and testbench



---
 rtl/prod7seg_pkg.sv | 34 +++
 rtl/bcd_to_seg7.sv | 38 +++
 rtl/product_to_7seg.sv | 175 +++++++++++++++++
 tb/tb_product_to_7seg.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prod7seg_pkg.sv
// -----------------------------------------------------------------------------
// prod7seg_pkg
// Shared definitions for the product-to-7-segment converter:
//   - segment codes (bit order a..g, MSB = a) for digits 0..9, blank and dash
//   - the converter FSM state encoding
//   - BCD width and overflow limit for the default four-digit display
// -----------------------------------------------------------------------------
package prod7seg_pkg;

  localparam int DIGITS_DEF = 4;
  localparam int BCD_W      = 4 * DIGITS_DEF;
  localparam int OVF_LIMIT  = 9999;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    ENC  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Purely combinational BCD digit to 7-segment encoder.
//   bcd   in  4  BCD digit 0..9
//   blank in  1  1 = drive all segments off regardless of bcd
//   seg   out 7  segment code, a..g with a in the MSB
// Non-decimal nibbles (10..15) cannot occur in a converted value; they show a
// dash so a corrupted digit is visible rather than silently plausible.
// -----------------------------------------------------------------------------
module bcd_to_seg7
  import prod7seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/product_to_7seg.sv
// -----------------------------------------------------------------------------
// product_to_7seg
// Converts a signed W-bit product into a sign bit plus DIGITS 7-segment decimal
// digits. The magnitude is converted with one double-dabble (add-3 / shift)
// iteration per clock, then the digits are encoded and presented on a
// valid/ready output port.
//   clk        in   1           rising-edge clock
//   rst_n      in   1           asynchronous active-low reset
//   in_valid   in   1           in_product is valid
//   in_ready   out  1           block is idle and accepts a product
//   in_product in   W           two's-complement product
//   out_valid  out  1           out_seg / out_ovf hold a fresh result
//   out_ready  in   1           consumer takes the result
//   out_seg    out  1+7*DIGITS  {sign, d[DIGITS-1], ..., d0}, each a..g
//   out_ovf    out  1           magnitude exceeds 9999 (digits show dashes)
// The displayed value persists after the handshake until the next result.
// -----------------------------------------------------------------------------
module product_to_7seg
  import prod7seg_pkg::*;
#(
  parameter int W          = 15,
  parameter int DIGITS     = DIGITS_DEF,
  parameter bit BLANK_LEAD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_product,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7*DIGITS:0]     out_seg,
  output logic                  out_ovf
);

  localparam int            BW    = 4 * DIGITS;
  localparam int            CNT_W = $clog2(W + 1);
  localparam logic [W-1:0]  LIMIT = W'(OVF_LIMIT);

  state_e                state_q, state_d;
  logic                  sign_q, sign_d;
  logic [W-1:0]          mag_q, mag_d;
  logic                  ovf_q, ovf_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7*DIGITS:0]     out_seg_q, out_seg_d;
  logic                  out_ovf_q, out_ovf_d;
  logic                  out_valid_q, out_valid_d;

  logic [W-1:0]          in_mag;
  logic [BW-1:0]         bcd_adj;
  logic [DIGITS-1:0]     blank;
  logic [7*DIGITS-1:0]   digit_seg;

  // Negating the most negative value wraps to itself, which read as unsigned
  // is exactly its magnitude (-16384 -> 16384 for W=15).
  assign in_mag = in_product[W-1] ? -in_product : in_product;

  // Add-3 correction of every nibble that would exceed 9 after the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero blanking: a digit is blank when it and every digit above it
  // are zero. The units digit is never blanked, so zero shows as "0".
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank      = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (bcd_q[4*i +: 4] == 4'd0);
      blank[i]   = BLANK_LEAD && upper_zero;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_to_seg7 u_enc (
      .bcd   (bcd_q[4*g +: 4]),
      .blank (blank[g]),
      .seg   (digit_seg[7*g +: 7])
    );
  end

  // NOTE: every *_d is given its hold value before the case statement, so no
  // path through the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    ovf_d       = ovf_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    out_seg_d   = out_seg_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_product[W-1];
          mag_d   = in_mag;
          ovf_d   = (in_mag > LIMIT);
          bcd_d   = '0;
          cnt_d   = CNT_W'(W);
          state_d = CONV;
        end
      end

      CONV: begin
        bcd_d = {bcd_adj[BW-2:0], mag_q[W-1]};
        mag_d = {mag_q[W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        // A digit carried out of the BCD window can only mean overflow; keep
        // the flag sticky on it rather than silently dropping the bit.
        ovf_d = ovf_q | bcd_adj[BW-1];
        if (cnt_q == CNT_W'(1)) begin
          state_d = ENC;
        end
      end

      ENC: begin
        out_seg_d   = ovf_q ? {sign_q, {DIGITS{SEG_DASH}}} : {sign_q, digit_seg};
        out_ovf_d   = ovf_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      ovf_q       <= 1'b0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      out_seg_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      ovf_q       <= ovf_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      out_seg_q   <= out_seg_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_seg   = out_seg_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_product_to_7seg.sv
// -----------------------------------------------------------------------------
// tb_product_to_7seg
// Self-checking bench for product_to_7seg. Two instances run in lockstep on
// the same stimulus: one with leading-zero blanking, one without. Expected
// results come from an independent decimal reference model, are queued when
// the DUT accepts a product and compared when the DUT hands a result out.
// -----------------------------------------------------------------------------
module tb_product_to_7seg;

  localparam int W  = 15;
  localparam int SW = 29;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  in_product = '0;

  logic          in_ready, out_valid, out_ovf;
  logic [SW-1:0] out_seg;
  logic          in_ready_z, out_valid_z, out_ovf_z;
  logic [SW-1:0] out_seg_z;

  typedef struct packed {
    logic          ovf;
    logic [SW-1:0] seg;
  } res_t;

  typedef struct packed {
    res_t bl;   // BLANK_LEAD = 1 instance
    res_t nb;   // BLANK_LEAD = 0 instance
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011};

  product_to_7seg #(.W(W), .DIGITS(4), .BLANK_LEAD(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_seg    (out_seg),
    .out_ovf    (out_ovf)
  );

  product_to_7seg #(.W(W), .DIGITS(4), .BLANK_LEAD(1'b0)) dut_z (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready_z),
    .in_product (in_product),
    .out_valid  (out_valid_z),
    .out_ready  (out_ready),
    .out_seg    (out_seg_z),
    .out_ovf    (out_ovf_z)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic res_t model(input int v, input bit bl);
    res_t       r;
    int         mag;
    int         p;
    logic [6:0] code;
    mag   = (v < 0) ? -v : v;
    p     = 1;
    r.ovf = (mag > 9999);
    r.seg = '0;
    r.seg[SW-1] = (v < 0);
    for (int i = 0; i < 4; i++) begin
      if (r.ovf)                       code = 7'b0000001;
      else if (bl && i > 0 && mag < p) code = 7'b0000000;
      else                             code = seg_tab[(mag / p) % 10];
      r.seg[7*i +: 7] = code;
      p = p * 10;
    end
    return r;
  endfunction

  // Scoreboard consumer: a result leaves the DUT on the edge after a negedge
  // that sees out_valid && out_ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_output", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("seg",        out_seg,     e.bl.seg);
        check("ovf",        out_ovf,     e.bl.ovf);
        check("z_valid",    out_valid_z, 1'b1);
        check("z_seg",      out_seg_z,   e.nb.seg);
        check("z_ovf",      out_ovf_z,   e.nb.ovf);
      end
    end
  end

  // Offer v until accepted; returns the cycle count just after the accept edge.
  task automatic send(input int v, output int acc);
    exp_t e;
    int   budget;
    budget     = 0;
    in_product = W'(v);
    in_valid   = 1'b1;
    while (!in_ready && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      acc      = cyc;
      return;
    end
    e.bl = model(v, 1'b1);
    e.nb = model(v, 1'b0);
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc      = cyc;
  endtask

  task automatic wait_valid(input int c0, output int lat);
    int budget;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!out_valid && budget < 100);
    if (!out_valid) check("valid_timeout", 32'd0, 32'd1);
    lat = cyc - c0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!(sb_q.size() == 0 && in_ready && !out_valid) && budget < 400);
    if (!(sb_q.size() == 0 && in_ready && !out_valid)) check("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int            acc, lat, h, v;
    logic [SW-1:0] held;
    int            dir_vals [7] = '{0, 10000, -16384, 9999, -9999, 16383, -1};

    // Reset state, sampled while rst_n is still low.
    #3;
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_seg",   out_seg,   '0);
    check("rst_out_ovf",   out_ovf,   1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: latency and a small negative value.
    out_ready = 1'b1;
    send(-84, acc);
    wait_valid(acc, lat);
    check("t1_latency", lat, 32'd16);
    check("t1_seg", out_seg, {1'b1, 7'b0000000, 7'b0000000, 7'b1111111, 7'b0110011});
    check("t1_ovf", out_ovf, 1'b0);
    wait_idle();

    // 2: four-digit value, then a single digit (zeros shown on dut_z).
    send(9801, acc);
    send(7, acc);
    wait_idle();
    check("t2_z_seg", out_seg_z, {1'b0, 7'b1111110, 7'b1111110, 7'b1111110, 7'b1110000});

    // 3: zero and the overflow / range boundaries.
    foreach (dir_vals[i]) send(dir_vals[i], acc);
    wait_idle();

    // 4: consumer stall; a new product offered while busy must wait.
    out_ready = 1'b0;
    send(321, acc);
    wait_valid(acc, lat);
    held = out_seg;
    @(posedge clk); #1;
    in_product = W'(12345);
    in_valid   = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("t4_hold_seg",   out_seg,   held);
      check("t4_hold_valid", out_valid, 1'b1);
      check("t4_busy",       in_ready,  1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    h = cyc;
    send(12345, acc);
    check("t4_accept_next", acc - h, 32'd2);
    check("t4_persist",     out_seg, held);
    wait_idle();
    check("t4_ovf_shown", out_ovf, 1'b1);

    // 5: reset in the middle of a conversion.
    send(4321, acc);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_seg",   out_seg,   '0);
    check("t5_rst_ovf",   out_ovf,   1'b0);
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_ready", in_ready,  1'b1);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    send(123, acc);
    wait_valid(acc, lat);
    check("t5_seg", out_seg, {1'b0, 7'b0000000, 7'b0110000, 7'b1101101, 7'b1111001});
    wait_idle();

    // 6: random sweep, back-to-back.
    repeat (500) begin
      v = int'($urandom_range(32767, 0)) - 16384;
      send(v, acc);
    end
    wait_idle();
    check("sb_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    checks++;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
